// File: rtl/svm_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : svm_txn_arbiter
// Description : Round-robin ingress arbiter and single-outstanding issue
//               controller for the SVM scheduler transaction port.
//               Optional conflict retry/backoff: define SVM_ARB_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module svm_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DEP_BITS       = 65536,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*64-1:0]         req_programID,
    input  logic [NUM_REQ*DEP_BITS-1:0]   req_read_deps,
    input  logic [NUM_REQ*DEP_BITS-1:0]   req_write_deps,
    output logic [63:0]                   owner_programID,
    output logic [DEP_BITS-1:0]           read_dependencies,
    output logic [DEP_BITS-1:0]           write_dependencies,
    output logic                          transaction_valid,
    input  logic                          transaction_accepted,
    input  logic                          has_conflict,
    input  logic [63:0]                   conflicting_id,
    output logic                          resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    resp_port,
    output logic [1:0]                    resp_status,
    output logic [63:0]                   resp_programID,
    output logic [63:0]                   resp_conflict_id,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] STATUS_ACCEPT   = 2'd0;
    localparam logic [1:0] STATUS_CONFLICT = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                 state_q,        state_d;
    logic [PTR_W-1:0]       rr_ptr_q,       rr_ptr_d;
    logic [PTR_W-1:0]       port_q,         port_d;
    logic [TMO_W-1:0]       tmo_cnt_q,      tmo_cnt_d;
    logic [63:0]            owner_pid_q,    owner_pid_d;
    logic [DEP_BITS-1:0]    rd_deps_q,      rd_deps_d;
    logic [DEP_BITS-1:0]    wr_deps_q,      wr_deps_d;
    logic                   txn_valid_q,    txn_valid_d;
    logic                   resp_valid_q,   resp_valid_d;
    logic [PTR_W-1:0]       resp_port_q,    resp_port_d;
    logic [1:0]             resp_status_q,  resp_status_d;
    logic [63:0]            resp_pid_q,     resp_pid_d;
    logic [63:0]            resp_cid_q,     resp_cid_d;
    logic                   busy_q,         busy_d;

`ifdef SVM_ARB_RETRY_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);

    logic [RTY_W-1:0]       retry_cnt_q,    retry_cnt_d;
    logic [BO_W-1:0]        bo_cnt_q,       bo_cnt_d;
`else
    logic                   unused_cfg;
    assign unused_cfg = ^{MAX_RETRY[0], BACKOFF_CYCLES[0]};
`endif

    logic                   gnt_found;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       scan_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search: first valid port at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
            scan_idx = ptr_inc(scan_idx);
        end
    end

    // Gated by rst_n so that no port sees a grant while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        port_d        = port_q;
        tmo_cnt_d     = tmo_cnt_q;
        owner_pid_d   = owner_pid_q;
        rd_deps_d     = rd_deps_q;
        wr_deps_d     = wr_deps_q;
        txn_valid_d   = txn_valid_q;
        resp_valid_d  = 1'b0;
        resp_port_d   = resp_port_q;
        resp_status_d = resp_status_q;
        resp_pid_d    = resp_pid_q;
        resp_cid_d    = resp_cid_q;
`ifdef SVM_ARB_RETRY_EN
        retry_cnt_d   = retry_cnt_q;
        bo_cnt_d      = bo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    owner_pid_d = req_programID[int'(gnt_idx) * 64 +: 64];
                    rd_deps_d   = req_read_deps[int'(gnt_idx) * DEP_BITS +: DEP_BITS];
                    wr_deps_d   = req_write_deps[int'(gnt_idx) * DEP_BITS +: DEP_BITS];
                    port_d      = gnt_idx;
                    rr_ptr_d    = ptr_inc(gnt_idx);
                    tmo_cnt_d   = '0;
                    txn_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
`ifdef SVM_ARB_RETRY_EN
                    retry_cnt_d = '0;
`endif
                end
            end

            ST_ISSUE: begin
                if (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES)) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                // Conflict outranks a simultaneous accept.
                if (has_conflict) begin
`ifdef SVM_ARB_RETRY_EN
                    if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                        txn_valid_d = 1'b0;
                        bo_cnt_d    = '0;
                        state_d     = ST_BACKOFF;
                    end else
`endif
                    begin
                        txn_valid_d   = 1'b0;
                        resp_valid_d  = 1'b1;
                        resp_port_d   = port_q;
                        resp_status_d = STATUS_CONFLICT;
                        resp_pid_d    = owner_pid_q;
                        resp_cid_d    = conflicting_id;
                        state_d       = ST_RESP;
                    end
                end else if (transaction_accepted) begin
                    txn_valid_d   = 1'b0;
                    resp_valid_d  = 1'b1;
                    resp_port_d   = port_q;
                    resp_status_d = STATUS_ACCEPT;
                    resp_pid_d    = owner_pid_q;
                    resp_cid_d    = '0;
                    state_d       = ST_RESP;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
                    txn_valid_d   = 1'b0;
                    resp_valid_d  = 1'b1;
                    resp_port_d   = port_q;
                    resp_status_d = STATUS_TIMEOUT;
                    resp_pid_d    = owner_pid_q;
                    resp_cid_d    = '0;
                    state_d       = ST_RESP;
                end
            end

`ifdef SVM_ARB_RETRY_EN
            ST_BACKOFF: begin
                if (bo_cnt_q == BO_W'(BACKOFF_CYCLES - 1)) begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    tmo_cnt_d   = '0;
                    txn_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    bo_cnt_d = bo_cnt_q + 1'b1;
                end
            end
`endif

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                txn_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            port_q        <= '0;
            tmo_cnt_q     <= '0;
            owner_pid_q   <= '0;
            rd_deps_q     <= '0;
            wr_deps_q     <= '0;
            txn_valid_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_port_q   <= '0;
            resp_status_q <= '0;
            resp_pid_q    <= '0;
            resp_cid_q    <= '0;
            busy_q        <= 1'b0;
`ifdef SVM_ARB_RETRY_EN
            retry_cnt_q   <= '0;
            bo_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            port_q        <= port_d;
            tmo_cnt_q     <= tmo_cnt_d;
            owner_pid_q   <= owner_pid_d;
            rd_deps_q     <= rd_deps_d;
            wr_deps_q     <= wr_deps_d;
            txn_valid_q   <= txn_valid_d;
            resp_valid_q  <= resp_valid_d;
            resp_port_q   <= resp_port_d;
            resp_status_q <= resp_status_d;
            resp_pid_q    <= resp_pid_d;
            resp_cid_q    <= resp_cid_d;
            busy_q        <= busy_d;
`ifdef SVM_ARB_RETRY_EN
            retry_cnt_q   <= retry_cnt_d;
            bo_cnt_q      <= bo_cnt_d;
`endif
        end
    end

    assign owner_programID    = owner_pid_q;
    assign read_dependencies  = rd_deps_q;
    assign write_dependencies = wr_deps_q;
    assign transaction_valid  = txn_valid_q;
    assign resp_valid         = resp_valid_q;
    assign resp_port          = resp_port_q;
    assign resp_status        = resp_status_q;
    assign resp_programID     = resp_pid_q;
    assign resp_conflict_id   = resp_cid_q;
    assign busy               = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_svm_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_svm_txn_arbiter
// Description : Directed self-checking bench for svm_txn_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svm_txn_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DEP_BITS = 64;
    localparam int TMO      = 16;
    localparam int MR       = 2;
    localparam int BO       = 4;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*64-1:0]       req_programID = '0;
    logic [NUM_REQ*DEP_BITS-1:0] req_read_deps = '0;
    logic [NUM_REQ*DEP_BITS-1:0] req_write_deps = '0;
    logic [63:0]                 owner_programID;
    logic [DEP_BITS-1:0]         read_dependencies;
    logic [DEP_BITS-1:0]         write_dependencies;
    logic                        transaction_valid;
    logic                        transaction_accepted = 1'b0;
    logic                        has_conflict = 1'b0;
    logic [63:0]                 conflicting_id = '0;
    logic                        resp_valid;
    logic [1:0]                  resp_port;
    logic [1:0]                  resp_status;
    logic [63:0]                 resp_programID;
    logic [63:0]                 resp_conflict_id;
    logic                        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    svm_txn_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DEP_BITS       (DEP_BITS),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MR),
        .BACKOFF_CYCLES (BO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_programID        (req_programID),
        .req_read_deps        (req_read_deps),
        .req_write_deps       (req_write_deps),
        .owner_programID      (owner_programID),
        .read_dependencies    (read_dependencies),
        .write_dependencies   (write_dependencies),
        .transaction_valid    (transaction_valid),
        .transaction_accepted (transaction_accepted),
        .has_conflict         (has_conflict),
        .conflicting_id       (conflicting_id),
        .resp_valid           (resp_valid),
        .resp_port            (resp_port),
        .resp_status          (resp_status),
        .resp_programID       (resp_programID),
        .resp_conflict_id     (resp_conflict_id),
        .busy                 (busy)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        transaction_accepted = 1'b0;
        has_conflict = 1'b0;
        conflicting_id = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready got %b expected 0000", req_ready); end
        n_cmp++; if (transaction_valid !== 1'b0) begin n_err++; $display("FAIL reset_txn_valid got %b expected 0", transaction_valid); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_cmp++; if (owner_programID !== 64'h0) begin n_err++; $display("FAIL reset_owner got %h expected 0", owner_programID); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int hi;
        req_programID = '0;
        req_read_deps = '0;
        req_write_deps = '0;
        req_programID[63:0] = 64'h1;
        req_write_deps[5] = 1'b1;
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (transaction_valid !== 1'b1) begin n_err++; $display("FAIL single_txn_valid got %b expected 1", transaction_valid); end
        n_cmp++; if (owner_programID !== 64'h1) begin n_err++; $display("FAIL single_owner got %h expected 1", owner_programID); end
        n_cmp++; if (write_dependencies !== 64'h20) begin n_err++; $display("FAIL single_wdeps got %h expected 20", write_dependencies); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b expected 1", busy); end
        hi = 1;
        @(negedge clk);
        if (transaction_valid === 1'b1) hi++;
        transaction_accepted = 1'b1;
        @(negedge clk);
        transaction_accepted = 1'b0;
        if (transaction_valid === 1'b1) hi++;
        n_cmp++; if (hi !== 2) begin n_err++; $display("FAIL single_valid_cycles got %0d expected 2", hi); end
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL single_resp_valid got %b expected 1", resp_valid); end
        n_cmp++; if (resp_port !== 2'd0) begin n_err++; $display("FAIL single_resp_port got %0d expected 0", resp_port); end
        n_cmp++; if (resp_status !== 2'd0) begin n_err++; $display("FAIL single_status got %0d expected 0", resp_status); end
        n_cmp++; if (resp_programID !== 64'h1) begin n_err++; $display("FAIL single_resp_pid got %h expected 1", resp_programID); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_resp_pulse got %b expected 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [1:0] exp_port;
        logic [3:0] exp_ready;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        apply_reset();
        for (int p = 0; p < NUM_REQ; p++) req_programID[p*64 +: 64] = 64'h10 + 64'(p);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_port = order[k];
            exp_ready = 4'b0001 << exp_port;
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rr_ready[%0d] got %b expected %b", k, req_ready, exp_ready); end
            @(negedge clk);
            n_cmp++; if (owner_programID !== 64'h10 + 64'(exp_port)) begin n_err++; $display("FAIL rr_owner[%0d] got %h expected %h", k, owner_programID, 64'h10 + 64'(exp_port)); end
            transaction_accepted = 1'b1;
            @(negedge clk);
            transaction_accepted = 1'b0;
            n_cmp++; if (resp_valid !== 1'b1 || resp_port !== exp_port) begin n_err++; $display("FAIL rr_resp[%0d] got valid %b port %0d expected valid 1 port %0d", k, resp_valid, resp_port, exp_port); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

`ifndef SVM_ARB_RETRY_EN
    task automatic test_conflict();
        int extra;
        req_programID[2*64 +: 64] = 64'h4;
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL conf_ready got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        has_conflict = 1'b1;
        conflicting_id = 64'h3;
        @(negedge clk);
        has_conflict = 1'b0;
        conflicting_id = '0;
        n_cmp++; if (resp_valid !== 1'b1 || resp_status !== 2'd1) begin n_err++; $display("FAIL conf_resp got valid %b status %0d expected valid 1 status 1", resp_valid, resp_status); end
        n_cmp++; if (resp_conflict_id !== 64'h3) begin n_err++; $display("FAIL conf_cid got %h expected 3", resp_conflict_id); end
        n_cmp++; if (resp_port !== 2'd2 || resp_programID !== 64'h4) begin n_err++; $display("FAIL conf_port_pid got %0d/%h expected 2/4", resp_port, resp_programID); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (transaction_valid !== 1'b0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL conf_reissue got %0d extra valid cycles expected 0", extra); end
    endtask

    task automatic test_both();
        req_programID[1*64 +: 64] = 64'h5;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        has_conflict = 1'b1;
        transaction_accepted = 1'b1;
        conflicting_id = 64'h7;
        @(negedge clk);
        has_conflict = 1'b0;
        transaction_accepted = 1'b0;
        conflicting_id = '0;
        n_cmp++; if (resp_valid !== 1'b1 || resp_status !== 2'd1) begin n_err++; $display("FAIL both_status got valid %b status %0d expected valid 1 status 1", resp_valid, resp_status); end
        n_cmp++; if (resp_conflict_id !== 64'h7) begin n_err++; $display("FAIL both_cid got %h expected 7", resp_conflict_id); end
        @(negedge clk);
    endtask
`else
    task automatic test_retry_then_accept();
        int gap;
        apply_reset();
        req_programID[63:0] = 64'h20;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (transaction_valid !== 1'b1 || owner_programID !== 64'h20) begin n_err++; $display("FAIL retry_issue[%0d] got valid %b id %h expected 1/20", i, transaction_valid, owner_programID); end
            if (i < 2) begin
                has_conflict = 1'b1;
                conflicting_id = 64'h30;
            end else begin
                transaction_accepted = 1'b1;
            end
            @(negedge clk);
            has_conflict = 1'b0;
            transaction_accepted = 1'b0;
            conflicting_id = '0;
            if (i < 2) begin
                n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL retry_backoff[%0d] got resp %b busy %b expected 0/1", i, resp_valid, busy); end
                gap = 0;
                while (transaction_valid === 1'b0 && gap < 20) begin
                    gap++;
                    @(negedge clk);
                end
                n_cmp++; if (gap !== BO) begin n_err++; $display("FAIL retry_gap[%0d] got %0d expected %0d", i, gap, BO); end
            end
        end
        n_cmp++; if (resp_valid !== 1'b1 || resp_status !== 2'd0) begin n_err++; $display("FAIL retry_accept got valid %b status %0d expected 1/0", resp_valid, resp_status); end
        @(negedge clk);
    endtask

    task automatic test_retry_exhaust();
        int issues;
        int guard;
        apply_reset();
        req_programID[63:0] = 64'h21;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        issues = 0;
        guard = 0;
        while (resp_valid !== 1'b1 && guard < 60) begin
            if (transaction_valid === 1'b1) begin
                issues++;
                has_conflict = 1'b1;
                conflicting_id = 64'h31;
            end
            @(negedge clk);
            has_conflict = 1'b0;
            conflicting_id = '0;
            guard++;
        end
        n_cmp++; if (issues !== MR + 1) begin n_err++; $display("FAIL exhaust_issues got %0d expected %0d", issues, MR + 1); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_status !== 2'd1 || resp_conflict_id !== 64'h31) begin n_err++; $display("FAIL exhaust_resp got valid %b status %0d cid %h expected 1/1/31", resp_valid, resp_status, resp_conflict_id); end
        @(negedge clk);
    endtask
`endif

    task automatic test_timeout();
        int hi;
        apply_reset();
        req_programID[3*64 +: 64] = 64'h9;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        hi = 0;
        while (transaction_valid === 1'b1 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== TMO + 1) begin n_err++; $display("FAIL tmo_cycles got %0d expected %0d", hi, TMO + 1); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_status !== 2'd2) begin n_err++; $display("FAIL tmo_status got valid %b status %0d expected 1/2", resp_valid, resp_status); end
        n_cmp++; if (resp_conflict_id !== 64'h0 || resp_port !== 2'd3) begin n_err++; $display("FAIL tmo_cid_port got %h/%0d expected 0/3", resp_conflict_id, resp_port); end
        @(negedge clk);
        n_cmp++; if (transaction_valid !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_after got valid %b resp %b expected 0/0", transaction_valid, resp_valid); end
    endtask

    task automatic test_reset_mid();
        int stray;
        req_programID[1*64 +: 64] = 64'hA;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (transaction_valid !== 1'b1) begin n_err++; $display("FAIL rmid_issue got %b expected 1", transaction_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (transaction_valid !== 1'b0 || busy !== 1'b0 || owner_programID !== 64'h0) begin n_err++; $display("FAIL rmid_async got valid %b busy %b id %h expected 0/0/0", transaction_valid, busy, owner_programID); end
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) stray++;
        end
        rst_n = 1'b1;
        req_valid = 4'hF;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_restart got %b expected 0001", req_ready); end
        req_valid = '0;
        @(negedge clk);
        if (resp_valid !== 1'b0) stray++;
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL rmid_no_resp got %0d stray pulses expected 0", stray); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
`ifndef SVM_ARB_RETRY_EN
        test_conflict();
        test_both();
`else
        test_retry_then_accept();
        test_retry_exhaust();
`endif
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svm_txn_arbiter.md
# svm_txn_arbiter

Multi-requester ingress arbiter and issue controller for the SVM hardware scheduler's single transaction port. It accepts transactions (program ID plus read/write dependency bitmaps) from `NUM_REQ` independent sources and grants them round-robin. It drives one transaction at a time into the scheduler's filter/insertion/batch pipeline, holding `transaction_valid` until the scheduler reports acceptance, conflict or timeout. It then returns a one-cycle completion to the originating requester.

## Interface
- `NUM_REQ`, 4: number of requester ports (2..16).
- `DEP_BITS`, 65536: width of each dependency bitmap (1024 deps x 64 bits).
- `TIMEOUT_CYCLES`, 256: maximum cycles in ISSUE without a scheduler response.
- `MAX_RETRY`, 3: conflict re-issues per transaction (retry build only).
- `BACKOFF_CYCLES`, 8: idle cycles between a conflict and its re-issue (retry build only).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-port request valid.
- `req_ready`  out  NUM_REQ  per-port grant/ready; at most one bit is high.
- `req_programID`  in  NUM_REQ*64  packed owner IDs; port p is at `[p*64 +: 64]`.
- `req_read_deps`  in  NUM_REQ*DEP_BITS  packed read bitmaps.
- `req_write_deps`  in  NUM_REQ*DEP_BITS  packed write bitmaps.
- `owner_programID`  out  64  to scheduler; registered.
- `read_dependencies`  out  DEP_BITS  to scheduler; registered.
- `write_dependencies`  out  DEP_BITS  to scheduler; registered.
- `transaction_valid`  out  1  to scheduler; registered.
- `transaction_accepted`  in  1  from scheduler.
- `has_conflict`  in  1  from scheduler.
- `conflicting_id`  in  64  from scheduler.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_port`  out  clog2(NUM_REQ)  originating port.
- `resp_status`  out  2  0 = accepted, 1 = conflict, 2 = timeout.
- `resp_programID`  out  64  echo of the issued ID.
- `resp_conflict_id`  out  64  captured `conflicting_id`; 0 unless the status is conflict.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
States: IDLE, ISSUE, BACKOFF, RESP.
- **IDLE:** the grant is the first asserted `req_valid` at or after `rr_ptr`, searching upward with wrap. `req_ready[g]` is combinational and asserted only in IDLE. A handshake (`req_valid & req_ready`) registers the payload into the downstream outputs, latches `g`, sets `rr_ptr = (g+1) mod NUM_REQ`, clears the timeout and retry counters, and moves to ISSUE.
- **ISSUE:** `transaction_valid = 1`. The timeout counter increments each cycle.
  - `has_conflict` sampled high goes to RESP with status 1 and captures `conflicting_id`. Conflict takes priority if `has_conflict` and `transaction_accepted` are both high.
  - `transaction_accepted` alone goes to RESP with status 0.
  - Counter reaching `TIMEOUT_CYCLES` with no response goes to RESP with status 2.
- **RESP:** `resp_valid` is high for exactly one cycle, `transaction_valid = 0`, then the state returns to IDLE. Payload registers hold their value until the next grant.
- BACKOFF is reachable only in the retry build (see Configuration).
- Requests are never dropped. A port whose `req_valid` falls before its grant loses its turn with no side effects.

## Timing
- Reset values: all outputs 0, `rr_ptr = 0`, state IDLE, all counters 0.
- Latency from grant handshake to `transaction_valid` high is 1 cycle.
- A scheduler response sampled at posedge N gives `transaction_valid` low and `resp_valid` high from N+1, for one cycle.
- Minimum spacing between consecutive issues is 3 cycles (ISSUE, RESP, IDLE grant).
- The earliest timeout gives `resp_valid` at `TIMEOUT_CYCLES + 1` cycles after entering ISSUE.
- The timeout counter is clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
- Responses arriving while not in ISSUE are ignored.
- Reset mid-operation: `rst_n` low immediately forces all outputs to 0, including `transaction_valid`. The in-flight transaction is lost and no `resp_valid` is generated.

## Configuration
- `SVM_ARB_RETRY_EN` defined: a conflict with retry count < `MAX_RETRY` goes to BACKOFF instead of RESP.
  - In BACKOFF, `transaction_valid = 0` for `BACKOFF_CYCLES` cycles, then the retry count increments and the state re-enters ISSUE with the same payload and the timeout counter cleared.
  - After `MAX_RETRY` failed re-issues, the next conflict reports status 1.
  - `busy` stays high throughout. Other requesters are not granted during backoff.
- Not defined: BACKOFF, `MAX_RETRY` and `BACKOFF_CYCLES` have no effect, and the first conflict reports status 1.

## Test plan
- Single request: port 0, ID 0x1, write bit 5; scheduler accepts 2 cycles into ISSUE -> `resp_valid` with port 0, status 0, `resp_programID` 0x1, `transaction_valid` high exactly 2 cycles.
- Round-robin fairness: ports 0..3 held valid continuously with IDs 0x10..0x13, all accepted -> grant order 0, 1, 2, 3, 0; `rr_ptr` wraps 3 -> 0.
- Conflict (retry build off): port 2, ID 0x4; scheduler asserts `has_conflict` with `conflicting_id` 0x3 -> status 1, `resp_conflict_id` 0x3, exactly one issue.
- Simultaneous `transaction_accepted` and `has_conflict` -> status 1.
- Timeout: `TIMEOUT_CYCLES = 16`, scheduler silent -> status 2, `resp_valid` 17 cycles after ISSUE entry, `transaction_valid` low after.
- Retry build, `MAX_RETRY = 2`, `BACKOFF_CYCLES = 4`:
  - Conflict on issues 1–2, accept on issue 3 -> status 0 with 4-cycle valid-low gaps between issues.
  - Conflict on all 3 issues -> status 1.
- Reset mid-operation: `rst_n` low during ISSUE -> `transaction_valid` 0 with no clock edge and no `resp_valid`; after release, the next grant starts from port 0.
